// File: rtl/dvp_pattern_gen.sv
// OV5640-style DVP transmitter: emits vsync/href and an RGB565 byte stream
// (high byte first) carrying one of four test patterns.
module dvp_pattern_gen #(
   parameter int          H_ACTIVE    = 800,
   parameter int          V_ACTIVE    = 480,
   parameter int          H_BLANK     = 64,
   parameter int          VSYNC_LEN   = 4,
   parameter int          V_BACK      = 8,
   parameter int          V_FRONT     = 4,
   parameter logic [15:0] SOLID_COLOR = 16'hF800
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [1:0] pattern_sel,
   output logic       cmos_vsync,
   output logic       cmos_href,
   output logic [7:0] cmos_data,
   output logic       frame_done,
   output logic [7:0] frame_cnt,
   output logic       busy
);

   localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
   localparam int COL_W    = $clog2(LINE_LEN);
   localparam int BAR_W    = H_ACTIVE / 8;
   localparam int BAR_CW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_VSYNC  = 3'd1,
      S_VBACK  = 3'd2,
      S_ACTIVE = 3'd3,
      S_VFRONT = 3'd4
   } state_e;

   state_e              state_q, state_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic [15:0]         line_q, line_d;
   logic [15:0]         last_line_s;
   logic [1:0]          sel_q, sel_d;
   logic [5:0]          x_q, x_d;
   logic [2:0]          bar_q, bar_d;
   logic [BAR_CW-1:0]   bar_cnt_q, bar_cnt_d;
   logic [15:0]         pix_cnt_q, pix_cnt_d;
   logic [15:0]         pixel_s;
   logic                vsync_q, vsync_d;
   logic                href_q, href_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;
   logic [7:0]          data_q, data_d;
   logic [7:0]          frame_cnt_q, frame_cnt_d;

   function automatic logic [15:0] bar_color(input logic [2:0] idx);
      logic [15:0] c;
      case (idx)
         3'd0:    c = 16'hFFFF;
         3'd1:    c = 16'hFFE0;
         3'd2:    c = 16'h07FF;
         3'd3:    c = 16'h07E0;
         3'd4:    c = 16'hF81F;
         3'd5:    c = 16'hF800;
         3'd6:    c = 16'h001F;
         default: c = 16'h0000;
      endcase
      return c;
   endfunction

   // Line and column counters walk every state; all lines share one length.
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      line_d      = line_q;
      sel_d       = sel_q;
      last_line_s = 16'd0;
      case (state_q)
         S_VSYNC:  last_line_s = 16'(VSYNC_LEN - 1);
         S_VBACK:  last_line_s = 16'(V_BACK - 1);
         S_ACTIVE: last_line_s = 16'(V_ACTIVE - 1);
         S_VFRONT: last_line_s = 16'(V_FRONT - 1);
         default:  last_line_s = 16'd0;
      endcase
      if (state_q == S_IDLE) begin
         if (enable) begin
            state_d = S_VSYNC;
            col_d   = '0;
            line_d  = 16'd0;
         end else begin
            state_d = S_IDLE;
         end
      end else if (col_q == COL_W'(LINE_LEN - 1)) begin
         col_d = '0;
         if (line_q == last_line_s) begin
            line_d = 16'd0;
            case (state_q)
               S_VSYNC:  state_d = S_VBACK;
               S_VBACK:  state_d = S_ACTIVE;
               S_ACTIVE: state_d = S_VFRONT;
               S_VFRONT: state_d = enable ? S_VSYNC : S_IDLE;
               default:  state_d = S_IDLE;
            endcase
         end else begin
            line_d = line_q + 16'd1;
         end
      end else begin
         col_d = col_q + COL_W'(1);
      end
      if (state_d == S_VSYNC && state_q != S_VSYNC) begin
         sel_d = pattern_sel;
      end else begin
         sel_d = sel_q;
      end
   end

   // Outputs are derived from the next state so each registers in step with it.
   always_comb begin
      vsync_d     = (state_d == S_VSYNC);
      href_d      = (state_d == S_ACTIVE) && (col_d < COL_W'(2 * H_ACTIVE));
      busy_d      = (state_d != S_IDLE);
      done_d      = (state_d == S_VFRONT) && (col_d == COL_W'(LINE_LEN - 1)) &&
                    (line_d == 16'(V_FRONT - 1));
      frame_cnt_d = done_d ? frame_cnt_q + 8'd1 : frame_cnt_q;
      x_d         = x_q;
      bar_d       = bar_q;
      bar_cnt_d   = bar_cnt_q;
      pix_cnt_d   = pix_cnt_q;
      pixel_s     = 16'h0000;
      case (sel_q)
         2'd0:    pixel_s = bar_color(bar_q);
         2'd1:    pixel_s = {x_q[4:0], x_q[5:0], x_q[4:0]};
         2'd2:    pixel_s = SOLID_COLOR;
         default: pixel_s = pix_cnt_q;
      endcase
      if (!href_d) begin
         x_d       = 6'd0;
         bar_d     = 3'd0;
         bar_cnt_d = '0;
         data_d    = 8'h00;
      end else if (col_d[0]) begin
         // Second byte of a pixel: advance all pixel trackers afterwards.
         data_d    = pixel_s[7:0];
         x_d       = x_q + 6'd1;
         pix_cnt_d = pix_cnt_q + 16'd1;
         if (bar_cnt_q == BAR_CW'(BAR_W - 1)) begin
            bar_cnt_d = '0;
            bar_d     = bar_q + 3'd1;
         end else begin
            bar_cnt_d = bar_cnt_q + BAR_CW'(1);
         end
      end else begin
         data_d = pixel_s[15:8];
      end
      if (state_d == S_VSYNC && state_q != S_VSYNC) begin
         pix_cnt_d = 16'd0;
      end else begin
         pix_cnt_d = pix_cnt_d;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         col_q       <= '0;
         line_q      <= 16'd0;
         sel_q       <= 2'd0;
         x_q         <= 6'd0;
         bar_q       <= 3'd0;
         bar_cnt_q   <= '0;
         pix_cnt_q   <= 16'd0;
         vsync_q     <= 1'b0;
         href_q      <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         data_q      <= 8'h00;
         frame_cnt_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         line_q      <= line_d;
         sel_q       <= sel_d;
         x_q         <= x_d;
         bar_q       <= bar_d;
         bar_cnt_q   <= bar_cnt_d;
         pix_cnt_q   <= pix_cnt_d;
         vsync_q     <= vsync_d;
         href_q      <= href_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         data_q      <= data_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign cmos_vsync = vsync_q;
   assign cmos_href  = href_q;
   assign cmos_data  = data_q;
   assign frame_done = done_q;
   assign frame_cnt  = frame_cnt_q;
   assign busy       = busy_q;

endmodule
